// File: rtl/pipelined_addsub.sv
// Carry-segmented pipelined adder/subtractor: one SEG_WIDTH ripple segment
// per stage, registered inter-segment carry, valid/ready with backpressure.
module pipelined_addsub #(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             msb_carry,
  output logic             overflow
);

  localparam int STAGES = WIDTH / SEG_WIDTH;
  localparam int SW     = SEG_WIDTH;
  localparam int LAST   = STAGES - 1;

  if (WIDTH % SEG_WIDTH != 0) begin : g_bad_seg
    $error("WIDTH must be a multiple of SEG_WIDTH");
  end

  typedef logic [WIDTH-1:0] word_t;

  word_t          a_q  [STAGES];
  word_t          b_q  [STAGES];
  word_t          s_q  [STAGES];
  logic           cy_q [STAGES];
  logic           v_q  [STAGES];
  logic           mc_q;

  word_t          a_i  [STAGES];
  word_t          b_i  [STAGES];
  word_t          s_i  [STAGES];
  word_t          s_n  [STAGES];
  logic           cy_i [STAGES];
  logic           cy_n [STAGES];
  logic           v_i  [STAGES];
  logic           mc_n;
  logic [SW+1:0]  seg_r;
  logic           adv;

  // Returns {carry into segment MSB, carry out, segment sum}
  function automatic logic [SW+1:0] seg_add(
    input logic [SW-1:0] x,
    input logic [SW-1:0] y,
    input logic          ci
  );
    logic [SW-1:0] s;
    logic          c;
    logic          m;
    s = '0;
    c = ci;
    m = ci;
    for (int i = 0; i < SW; i++) begin
      if (i == SW - 1) m = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {m, c, s};
  endfunction

  always_comb begin
    a_i[0]  = a;
    b_i[0]  = sub ? ~b : b;
    cy_i[0] = sub | c_in;
    s_i[0]  = '0;
    v_i[0]  = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_i[k]  = a_q[k-1];
      b_i[k]  = b_q[k-1];
      cy_i[k] = cy_q[k-1];
      s_i[k]  = s_q[k-1];
      v_i[k]  = v_q[k-1];
    end
    mc_n  = 1'b0;
    seg_r = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg_r = seg_add(a_i[k][k*SW +: SW],
                      b_i[k][k*SW +: SW],
                      cy_i[k]);
      s_n[k]              = s_i[k];
      s_n[k][k*SW +: SW]  = seg_r[SW-1:0];
      cy_n[k]             = seg_r[SW];
      if (k == LAST) mc_n = seg_r[SW+1];
    end
  end

  // Data only loads behind a valid token so outputs stay put across bubbles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
        cy_q[k] <= 1'b0;
      end
      mc_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_i[k];
        if (v_i[k]) begin
          a_q[k]  <= a_i[k];
          b_q[k]  <= b_i[k];
          s_q[k]  <= s_n[k];
          cy_q[k] <= cy_n[k];
        end
      end
      if (v_i[LAST]) mc_q <= mc_n;
    end
  end

  assign out_valid = v_q[LAST];
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign sum       = s_q[LAST];
  assign c_out     = cy_q[LAST];
  assign msb_carry = mc_q;
  assign overflow  = cy_q[LAST] ^ mc_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed + randomized bench for pipelined_addsub with a result
// scoreboard, latency, backpressure-stability and reset-flush checks.
module tb_pipelined_addsub;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        mc;
    logic        ov;
  } res_t;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        c_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        c_out;
  logic        msb_carry;
  logic        overflow;

  int   tests = 0;
  int   fails = 0;
  res_t sb[$];
  logic stalled = 1'b0;
  res_t held;

  pipelined_addsub #(.WIDTH(32), .SEG_WIDTH(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .msb_carry (msb_carry),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic res_t model(
    input logic [31:0] x, input logic [31:0] y,
    input logic ci, input logic s
  );
    logic [31:0] yy;
    logic        c0;
    logic [32:0] f;
    logic [31:0] l;
    res_t        r;
    yy   = s ? ~y : y;
    c0   = s ? 1'b1 : ci;
    f    = {1'b0, x} + {1'b0, yy} + {32'd0, c0};
    l    = {1'b0, x[30:0]} + {1'b0, yy[30:0]} + {31'd0, c0};
    r.s  = f[31:0];
    r.co = f[32];
    r.mc = l[31];
    r.ov = f[32] ^ l[31];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tb_,
                      input logic tc, input logic ts, input res_t e);
    int n;
    n = 0;
    @(negedge clock);
    a = ta; b = tb_; c_in = tc; sub = ts; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    else sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic lat_op(input logic [31:0] ta, input logic [31:0] tb_,
                        input logic tc, input logic ts, input res_t e);
    send(ta, tb_, tc, ts, e);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      chk($sformatf("latency_c%0d", i), 64'(out_valid),
          64'(i == 4));
    end
  endtask

  // Scoreboard / stability monitor, sampled mid low phase
  always begin
    @(negedge clock);
    #2;
    if (!reset_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        chk("hold_stable", 64'({sum, c_out, msb_carry, overflow}),
            64'(held));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'(sum), 64'hDEAD);
        end else begin
          res_t e;
          e = sb.pop_front();
          chk("sum", 64'(sum), 64'(e.s));
          chk("c_out", 64'(c_out), 64'(e.co));
          chk("msb_carry", 64'(msb_carry), 64'(e.mc));
          chk("overflow", 64'(overflow), 64'(e.ov));
        end
      end
      stalled = out_valid && !out_ready;
      held    = '{sum, c_out, msb_carry, overflow};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outs", 64'({sum, c_out, msb_carry, overflow}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    lat_op(32'h000000FF, 32'h1, 1'b0, 1'b0,
           '{32'h00000100, 1'b0, 1'b0, 1'b0});
    lat_op(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0,
           '{32'h00000000, 1'b1, 1'b1, 1'b0});
    lat_op(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0,
           '{32'h80000000, 1'b0, 1'b1, 1'b1});
    lat_op(32'd5, 32'd7, 1'b1, 1'b1,
           '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0});
    lat_op(32'h80000000, 32'h1, 1'b0, 1'b1,
           '{32'h7FFFFFFF, 1'b1, 1'b0, 1'b1});

    // Six back-to-back ops with a 3-cycle downstream stall
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [31:0] x, y;
          x = 32'h1111_0000 * (i + 1) + 32'hFF;
          y = 32'h0F0F_F0F1 + i;
          send(x, y, i[0], i[1], model(x, y, i[0], i[1]));
        end
        idle();
      end
      begin
        repeat (6) @(negedge clock);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          #1;
          chk("stall_out_valid", 64'(out_valid), 64'd1);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          @(negedge clock);
        end
        out_ready = 1'b1;
      end
    join
    repeat (8) @(negedge clock);
    chk("stream_drained", 64'(sb.size()), 64'd0);

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++)
      send(32'hA000_0000 + i, 32'h5, 1'b0, 1'b0,
           model(32'hA000_0000 + i, 32'h5, 1'b0, 1'b0));
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_outs",
        64'({sum, c_out, msb_carry, overflow}), 64'd0);
    sb.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      #1;
      chk("no_stale", 64'(out_valid), 64'd0);
    end
    lat_op(32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0,
           '{32'h0000_5555, 1'b0, 1'b0, 1'b0});

    // Random ops under random backpressure
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          logic [31:0] x, y;
          logic        cc, ss;
          x  = $urandom;
          y  = $urandom;
          cc = 1'($urandom_range(0, 1));
          ss = 1'($urandom_range(0, 1));
          send(x, y, cc, ss, model(x, y, cc, ss));
        end
        idle();
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clock);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clock);
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 60 && sb.size() != 0; i++)
      @(negedge clock);
    repeat (2) @(negedge clock);
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, carry-segmented pipelined adder/subtractor for the ALU datapath; the next generation of the fixed-width ripple-carry adder.
- Splits a WIDTH-bit add into STAGES = WIDTH/SEG_WIDTH ripple segments, one segment per pipeline stage.
- Registers the inter-segment carry between stages.
- Adds subtract mode, signed overflow and a valid/ready handshake with backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SEG_WIDTH, 8, bits resolved per pipeline stage. WIDTH % SEG_WIDTH must be 0, otherwise elaboration error. SEG_WIDTH = WIDTH gives a single stage.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; used in add mode only.
- sub  input  1  0 = A+B+c_in, 1 = A-B (A + ~B + 1; c_in ignored).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of MSB. In sub mode 1 = no borrow.
- msb_carry  output  1  carry into bit WIDTH-1.
- overflow  output  1  signed overflow = c_out XOR msb_carry.

Behaviour:
- Reset:
  - reset_n low asynchronously clears all stage valid bits, carries and result registers.
  - sum, c_out, msb_carry, overflow and out_valid read 0 during and after reset until the first result.
  - in_ready reads 1 after reset.
- Advance rule: adv = out_ready OR NOT out_valid. in_ready = adv (combinational).
  - When adv is 1, every stage register loads from its predecessor; stage 0 loads the inputs and captures valid = in_valid.
  - When adv is 0, all stages hold, including bubbles.
  - A transfer occurs when in_valid AND in_ready. A result is consumed when out_valid AND out_ready.
- Operand conditioning at stage 0: B' = sub ? ~b : b; carry0 = sub ? 1 : c_in.
- Stage k (0..STAGES-1):
  - Ripple-adds segment k of A and B' with the registered carry from stage k-1 (carry0 for stage 0).
  - Registers the segment sum, segment carry-out, and the still-unprocessed upper operand segments (skew delay).
  - Lower sum segments already computed shift along unchanged, so sum leaves aligned.
- Last stage: registers the final c_out and msb_carry (carry into bit WIDTH-1, taken inside the top segment). overflow is derived from these registered values.
- Latency: exactly STAGES cycles from accept to out_valid with no stall.
  - Throughput is one op per cycle while out_ready stays 1.
  - Order is preserved and no result is dropped or duplicated.
- Output stability: while out_valid = 1 and out_ready = 0, sum, c_out, msb_carry and overflow hold constant.
- Simultaneous accept and consume in one cycle is legal; the pipeline shifts by one.
- Wrap-around: the sum is modulo 2^WIDTH; carry out of the top is reported only on c_out.
- Reset mid-operation: all in-flight operations are discarded and none reappear after reset_n rises.
- Inputs are sampled only on transfer cycles; values while in_ready = 0 are don't-care.

Test Plan (WIDTH=32, SEG_WIDTH=8, STAGES=4):
- Add 0x000000FF + 0x00000001, c_in=0 -> sum 0x00000100, c_out 0, overflow 0; out_valid exactly 4 cycles after accept.
- Add 0xFFFFFFFF + 0x00000000, c_in=1 (carry crosses all 4 stages) -> sum 0x00000000, c_out 1, msb_carry 1, overflow 0.
- Add 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, msb_carry 1, c_out 0, overflow 1.
- Sub 5 - 7 (c_in=1, ignored) -> sum 0xFFFFFFFE, c_out 0, overflow 0. Sub 0x80000000 - 1 -> 0x7FFFFFFF, overflow 1.
- Stream 6 back-to-back ops with out_ready forced low for 3 cycles mid-stream -> in_ready low in those cycles; outputs held stable; all 6 results delivered in order, none lost or duplicated.
- Assert reset_n low with 3 ops in flight -> out_valid 0 immediately and all outputs 0; after release, no stale results emerge and the first new op returns after 4 cycles.
